// File: rtl/memtrace_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : memtrace_responder_if
//  Description : Per-lane memory trace request bus plus the response channel
//                returned by the memory-side responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface memtrace_responder_if #(
    parameter int NUM_LANES = 4
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                    trace_read_ready;
    logic [NUM_LANES-1:0]    trace_read_valid;
    logic [64*NUM_LANES-1:0] trace_read_address;
    logic [NUM_LANES-1:0]    trace_read_is_store;
    logic [32*NUM_LANES-1:0] trace_read_size;
    logic [64*NUM_LANES-1:0] trace_read_data;
    logic                    trace_read_finished;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [LANE_W-1:0]       resp_lane;
    logic                    resp_is_store;
    logic [63:0]             resp_data;
    logic                    resp_misaligned;

    // Trace source side: issues requests, consumes responses
    modport master (
        input  trace_read_ready,
        output trace_read_valid, trace_read_address, trace_read_is_store,
        output trace_read_size, trace_read_data, trace_read_finished,
        input  resp_valid, resp_lane, resp_is_store, resp_data, resp_misaligned,
        output resp_ready
    );

    // Memory side: accepts requests, produces responses
    modport slave (
        output trace_read_ready,
        input  trace_read_valid, trace_read_address, trace_read_is_store,
        input  trace_read_size, trace_read_data, trace_read_finished,
        output resp_valid, resp_lane, resp_is_store, resp_data, resp_misaligned,
        input  resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/memtrace_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memtrace_responder
//  Description : Memory-side endpoint for trace-driven sims. Buffers multi-lane
//                request beats and serves them lane by lane against a word-
//                addressed backing store. Optional counters: define
//                MEMTRACE_RESPONDER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module memtrace_responder #(
    parameter int NUM_LANES  = 4,
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    memtrace_responder_if.slave  bus,
    output logic                 done
`ifdef MEMTRACE_RESPONDER_STATS_EN
    ,
    output logic [31:0]          stat_loads,
    output logic [31:0]          stat_stores,
    output logic [31:0]          stat_misaligned
`endif
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int A_W    = IDX_W + 3;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // Request FIFO: one entry carries every lane field of a beat
    logic [NUM_LANES-1:0]     r_q_valid [FIFO_DEPTH];
    logic [A_W*NUM_LANES-1:0] r_q_addr  [FIFO_DEPTH];
    logic [NUM_LANES-1:0]     r_q_store [FIFO_DEPTH];
    logic [2*NUM_LANES-1:0]   r_q_size  [FIFO_DEPTH];
    logic [64*NUM_LANES-1:0]  r_q_data  [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_nonempty;

    logic [A_W*NUM_LANES-1:0] w_in_addr;
    logic [2*NUM_LANES-1:0]   w_in_size;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;

    logic [1:0]               r_state;
    logic [NUM_LANES-1:0]     r_pending;
    logic [A_W*NUM_LANES-1:0] r_addr;
    logic [NUM_LANES-1:0]     r_store;
    logic [2*NUM_LANES-1:0]   r_size;
    logic [64*NUM_LANES-1:0]  r_data;
    logic                     r_resp_valid;
    logic [LANE_W-1:0]        r_resp_lane;
    logic                     r_resp_store;
    logic [63:0]              r_resp_data;
    logic                     r_resp_mis;
    logic                     r_finished;
    logic                     r_done;

    logic [63:0]              r_mem [MEM_WORDS];

    logic [LANE_W-1:0]        w_lane;
    logic [NUM_LANES-1:0]     w_clear;
    logic [A_W-1:0]           w_addr;
    logic                     w_is_store;
    logic [1:0]               w_size;
    logic [63:0]              w_wdata;
    logic [IDX_W-1:0]         w_idx;
    logic [2:0]               w_off;
    logic [7:0]               w_bmask;
    logic [2:0]               w_amask;
    logic [7:0]               w_be;
    logic [63:0]              w_word;
    logic [63:0]              w_wshift;
    logic [63:0]              w_merged;
    logic [63:0]              w_lmask;
    logic [63:0]              w_load;
    logic                     w_mis;
    logic                     w_hs;

    // Only the address bits that reach the store are kept; sizes are clamped to 0..3
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_in
        assign w_in_addr[A_W*g +: A_W] = bus.trace_read_address[64*g +: A_W];
        assign w_in_size[2*g +: 2]     = (|bus.trace_read_size[32*g+2 +: 30]) ? 2'd3
                                         : bus.trace_read_size[32*g +: 2];
    end

    assign w_full               = (r_count == CNT_W'(FIFO_DEPTH));
    assign bus.trace_read_ready = ~w_full;
    assign w_push               = ~w_full & (|bus.trace_read_valid);
    assign w_pop                = (r_state == S_IDLE) & r_nonempty;
    assign w_hs                 = r_resp_valid & bus.resp_ready;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_valid[r_wr_ptr] <= bus.trace_read_valid;
            r_q_addr[r_wr_ptr]  <= w_in_addr;
            r_q_store[r_wr_ptr] <= bus.trace_read_is_store;
            r_q_size[r_wr_ptr]  <= w_in_size;
            r_q_data[r_wr_ptr]  <= bus.trace_read_data;
        end
    end

    // The pop decision uses a registered occupancy flag so it never depends
    // on a push landing in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_nonempty <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_nonempty <= (r_count != '0);
        end
    end

    // Lowest pending lane wins: descending scan lets the last hit stand
    always_comb begin
        w_lane     = '0;
        w_clear    = '0;
        w_addr     = '0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        w_wdata    = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lane     = LANE_W'(i);
                w_clear    = '0;
                w_clear[i] = 1'b1;
                w_addr     = r_addr[A_W*i +: A_W];
                w_is_store = r_store[i];
                w_size     = r_size[2*i +: 2];
                w_wdata    = r_data[64*i +: 64];
            end
        end
    end

    assign w_idx = w_addr[A_W-1:3];
    assign w_off = w_addr[2:0];

    always_comb begin
        w_bmask = 8'h01;
        w_amask = 3'b000;
        case (w_size)
            2'd1:    begin w_bmask = 8'h03; w_amask = 3'b001; end
            2'd2:    begin w_bmask = 8'h0F; w_amask = 3'b011; end
            2'd3:    begin w_bmask = 8'hFF; w_amask = 3'b111; end
            default: begin w_bmask = 8'h01; w_amask = 3'b000; end
        endcase
    end

    // 8-bit shift discards enables that would run past byte 7
    assign w_be     = w_bmask << w_off;
    assign w_word   = r_mem[w_idx];
    assign w_wshift = w_wdata << {w_off, 3'b000};
    assign w_load   = (w_word >> {w_off, 3'b000}) & w_lmask;
    assign w_mis    = (w_off & w_amask) != 3'b000;

    always_comb begin
        w_merged = w_word;
        w_lmask  = '0;
        for (int b = 0; b < 8; b++) begin
            if (w_be[b]) w_merged[8*b +: 8] = w_wshift[8*b +: 8];
            w_lmask[8*b +: 8] = {8{w_bmask[b]}};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && (r_state == S_SERVE) && w_is_store) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_addr       <= '0;
            r_store      <= '0;
            r_size       <= '0;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_lane  <= '0;
            r_resp_store <= 1'b0;
            r_resp_data  <= '0;
            r_resp_mis   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_pending <= r_q_valid[r_rd_ptr];
                        r_addr    <= r_q_addr[r_rd_ptr];
                        r_store   <= r_q_store[r_rd_ptr];
                        r_size    <= r_q_size[r_rd_ptr];
                        r_data    <= r_q_data[r_rd_ptr];
                        r_state   <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_lane  <= w_lane;
                    r_resp_store <= w_is_store;
                    r_resp_data  <= w_is_store ? 64'd0 : w_load;
                    r_resp_mis   <= w_mis;
                    r_pending    <= r_pending & ~w_clear;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= (r_pending != '0) ? S_SERVE : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_finished <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (bus.trace_read_finished) r_finished <= 1'b1;
            r_done <= r_finished && (r_count == '0) && (r_state == S_IDLE) && !r_resp_valid;
        end
    end

    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_lane       = r_resp_lane;
    assign bus.resp_is_store   = r_resp_store;
    assign bus.resp_data       = r_resp_data;
    assign bus.resp_misaligned = r_resp_mis;
    assign done                = r_done;

`ifdef MEMTRACE_RESPONDER_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_mis    <= '0;
        end else if (w_hs) begin
            if (r_resp_store && (r_stat_stores != 32'hFFFF_FFFF)) r_stat_stores <= r_stat_stores + 32'd1;
            if (!r_resp_store && (r_stat_loads != 32'hFFFF_FFFF)) r_stat_loads <= r_stat_loads + 32'd1;
            if (r_resp_mis && (r_stat_mis != 32'hFFFF_FFFF))      r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_loads      = r_stat_loads;
    assign stat_stores     = r_stat_stores;
    assign stat_misaligned = r_stat_mis;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_hs;
`endif
endmodule
`default_nettype wire
